// File: rtl/vga_coord_pipe_if.sv
// Coordinate pipe bus: raw sync-generator counters in, aligned pixel/tile
// coordinates, strobes and frame count out.
interface vga_coord_pipe_if #(
  parameter int CW      = 10,
  parameter int SW      = 1,
  parameter int FRAME_W = 8
);
  logic               pix_en;
  logic [CW-1:0]      h_cnt;
  logic [CW-1:0]      v_cnt;
  logic [CW-1:0]      xcoor;
  logic [CW-1:0]      ycoor;
  logic [CW-1:0]      tile_x;
  logic [CW-1:0]      tile_y;
  logic [SW-1:0]      sub_x;
  logic [SW-1:0]      sub_y;
  logic               active;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;

  // sync generator / renderer side
  modport master (
    output pix_en, h_cnt, v_cnt,
    input  xcoor, ycoor, tile_x, tile_y, sub_x, sub_y,
           active, line_start, frame_start, frame_cnt
  );

  // coordinate pipe side
  modport slave (
    input  pix_en, h_cnt, v_cnt,
    output xcoor, ycoor, tile_x, tile_y, sub_x, sub_y,
           active, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_coord_pipe.sv
// VGA coordinate pipe: turns raw h/v counters into active-area coordinates,
// tile coordinates, line/frame strobes and a wrapping frame counter, all
// delayed by LAT pixel-enabled cycles and mutually aligned.
module vga_coord_pipe #(
  parameter int CW          = 10,
  parameter int H_START     = 145,
  parameter int H_ACTIVE    = 480,
  parameter int V_START     = 13,
  parameter int V_ACTIVE    = 480,
  parameter int CLAMP_MODE  = 0,
  parameter int SCALE_SHIFT = 0,
  parameter int LAT         = 1,
  parameter int FRAME_W     = 8
) (
  input logic              clk,
  input logic              rst_n,
  vga_coord_pipe_if.slave  bus
);

  localparam int SW = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;

  // Window bounds are one bit wider than the counters so that
  // START+ACTIVE never wraps when compared.
  localparam logic [CW:0]   H_LO  = (CW+1)'(H_START);
  localparam logic [CW:0]   H_HI  = (CW+1)'(H_START + H_ACTIVE);
  localparam logic [CW:0]   V_LO  = (CW+1)'(V_START);
  localparam logic [CW:0]   V_HI  = (CW+1)'(V_START + V_ACTIVE);
  localparam logic [CW-1:0] H_OFF = CW'(H_START);
  localparam logic [CW-1:0] V_OFF = CW'(V_START);
  localparam logic [CW-1:0] X_MAX = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(V_ACTIVE - 1);

  typedef struct packed {
    logic [CW-1:0]      x;
    logic [CW-1:0]      y;
    logic [CW-1:0]      tx;
    logic [CW-1:0]      ty;
    logic [SW-1:0]      sx;
    logic [SW-1:0]      sy;
    logic               act;
    logic               ls;
    logic               fs;
    logic [FRAME_W-1:0] fc;
  } stage_t;

  stage_t             s0;
  stage_t             pipe [LAT];
  logic [FRAME_W-1:0] frame_ctr;
  logic               h_low;
  logic               v_low;
  logic               h_in;
  logic               v_in;
  logic [CW-1:0]      x_c;
  logic [CW-1:0]      y_c;

  // Window test happens before subtraction, so a wrapped difference is never
  // selected; tile/sub values come from the already-clamped coordinates.
  // Non-strobe samples carry the frame index captured by the last frame_start.
  always_comb begin
    h_low = ({1'b0, bus.h_cnt} < H_LO);
    v_low = ({1'b0, bus.v_cnt} < V_LO);
    h_in  = !h_low && ({1'b0, bus.h_cnt} < H_HI);
    v_in  = !v_low && ({1'b0, bus.v_cnt} < V_HI);

    x_c = '0;
    if (h_in)
      x_c = bus.h_cnt - H_OFF;
    else if (CLAMP_MODE != 0 && !h_low)
      x_c = X_MAX;

    y_c = '0;
    if (v_in)
      y_c = bus.v_cnt - V_OFF;
    else if (CLAMP_MODE != 0 && !v_low)
      y_c = Y_MAX;

    s0     = '0;
    s0.x   = x_c;
    s0.y   = y_c;
    s0.tx  = x_c >> SCALE_SHIFT;
    s0.ty  = y_c >> SCALE_SHIFT;
    s0.sx  = (SCALE_SHIFT == 0) ? '0 : x_c[SW-1:0];
    s0.sy  = (SCALE_SHIFT == 0) ? '0 : y_c[SW-1:0];
    s0.act = h_in && v_in;
    s0.ls  = s0.act && (bus.h_cnt == H_OFF);
    s0.fs  = s0.ls && (bus.v_cnt == V_OFF);
    s0.fc  = s0.fs ? frame_ctr : pipe[0].fc;
  end

  // Pipeline stages advance together on pix_en and flush on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++)
        pipe[i] <= '0;
    end else if (bus.pix_en) begin
      pipe[0] <= s0;
      for (int i = 1; i < LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  // Frame counter bumps after stage 1 has taken its value for a frame_start.
  always_ff @(posedge clk) begin
    if (!rst_n)
      frame_ctr <= '0;
    else if (bus.pix_en && s0.fs)
      frame_ctr <= frame_ctr + 1'b1;
  end

  assign bus.xcoor       = pipe[LAT-1].x;
  assign bus.ycoor       = pipe[LAT-1].y;
  assign bus.tile_x      = pipe[LAT-1].tx;
  assign bus.tile_y      = pipe[LAT-1].ty;
  assign bus.sub_x       = pipe[LAT-1].sx;
  assign bus.sub_y       = pipe[LAT-1].sy;
  assign bus.active      = pipe[LAT-1].act;
  assign bus.line_start  = pipe[LAT-1].ls;
  assign bus.frame_start = pipe[LAT-1].fs;
  assign bus.frame_cnt   = pipe[LAT-1].fc;

endmodule

// File: tb/tb_vga_coord_pipe.sv
// Testbench for vga_coord_pipe: two instances with different parameter sets
// share one stimulus stream. A sample-level reference model predicts every
// output; a directed table and hand sequences cover the corner cases.
module tb_vga_coord_pipe;

  typedef struct {
    int x, y, tx, ty, sx, sy, act, ls, fs, fc;
  } exp_t;

  typedef struct {
    int h, v;
    int ax, ay, aact, als, afs;
    int bx, by, btx, bty, bsx, bsy;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       pe;
  logic [9:0] hc;
  logic [9:0] vc;

  int total;
  int bad;

  exp_t qa[$];
  exp_t qb[$];
  exp_t last_exp [2];
  int   seen [2];
  int   cur_fc [2];

  vga_coord_pipe_if #(.CW(10), .SW(1), .FRAME_W(8)) ifa ();
  vga_coord_pipe_if #(.CW(10), .SW(2), .FRAME_W(2)) ifb ();

  assign ifa.pix_en = pe;
  assign ifa.h_cnt  = hc;
  assign ifa.v_cnt  = vc;
  assign ifb.pix_en = pe;
  assign ifb.h_cnt  = hc;
  assign ifb.v_cnt  = vc;

  vga_coord_pipe #(
    .LAT(2), .CLAMP_MODE(0), .SCALE_SHIFT(0), .FRAME_W(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );

  vga_coord_pipe #(
    .LAT(3), .CLAMP_MODE(1), .SCALE_SHIFT(2), .FRAME_W(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coordinate rules for a single sample: window, clamping, tiling, strobes.
  function automatic exp_t calc(int h, int v, int clamp, int ss);
    exp_t e;
    bit   hin, vin;
    hin = (h >= 145) && (h < 145 + 480);
    vin = (v >= 13) && (v < 13 + 480);
    e.x = hin ? h - 145 : ((clamp != 0 && h >= 145) ? 479 : 0);
    e.y = vin ? v - 13 : ((clamp != 0 && v >= 13) ? 479 : 0);
    e.tx = e.x / (1 << ss);
    e.ty = e.y / (1 << ss);
    e.sx = e.x % (1 << ss);
    e.sy = e.y % (1 << ss);
    e.act = (hin && vin) ? 1 : 0;
    e.ls  = (e.act == 1 && h == 145) ? 1 : 0;
    e.fs  = (e.ls == 1 && v == 13) ? 1 : 0;
    e.fc  = 0;
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t z;
    z = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    return z;
  endfunction

  function automatic exp_t act_a();
    exp_t r;
    r.x = int'(ifa.xcoor);   r.y = int'(ifa.ycoor);
    r.tx = int'(ifa.tile_x); r.ty = int'(ifa.tile_y);
    r.sx = int'(ifa.sub_x);  r.sy = int'(ifa.sub_y);
    r.act = int'(ifa.active); r.ls = int'(ifa.line_start);
    r.fs = int'(ifa.frame_start); r.fc = int'(ifa.frame_cnt);
    return r;
  endfunction

  function automatic exp_t act_b();
    exp_t r;
    r.x = int'(ifb.xcoor);   r.y = int'(ifb.ycoor);
    r.tx = int'(ifb.tile_x); r.ty = int'(ifb.tile_y);
    r.sx = int'(ifb.sub_x);  r.sy = int'(ifb.sub_y);
    r.act = int'(ifb.active); r.ls = int'(ifb.line_start);
    r.fs = int'(ifb.frame_start); r.fc = int'(ifb.frame_cnt);
    return r;
  endfunction

  function automatic bit same(exp_t a, exp_t b);
    return a.x == b.x && a.y == b.y && a.tx == b.tx && a.ty == b.ty &&
           a.sx == b.sx && a.sy == b.sy && a.act == b.act && a.ls == b.ls &&
           a.fs == b.fs && a.fc == b.fc;
  endfunction

  // Flushed pipeline: LAT-1 empty slots ahead of the first real sample.
  task automatic model_reset();
    qa.delete();
    qb.delete();
    qa.push_back(zero_exp());
    qb.push_back(zero_exp());
    qb.push_back(zero_exp());
    for (int d = 0; d < 2; d++) begin
      last_exp[d] = zero_exp();
      seen[d]     = 0;
      cur_fc[d]   = 0;
    end
  endtask

  // One enabled sample enters the model; the sample LAT samples old leaves.
  task automatic model_advance(input int h, input int v);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      e = calc(h, v, d, d * 2);
      if (e.fs == 1) begin
        cur_fc[d] = seen[d] % ((d == 0) ? 256 : 4);
        seen[d]++;
      end
      e.fc = cur_fc[d];
      if (d == 0) begin
        qa.push_back(e);
        last_exp[0] = qa.pop_front();
      end else begin
        qb.push_back(e);
        last_exp[1] = qb.pop_front();
      end
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_one(input string name, input exp_t got, input exp_t want);
    total++;
    if (!same(got, want)) begin
      bad++;
      $display("[TB] FAIL %s got x=%0d y=%0d tx=%0d ty=%0d sx=%0d sy=%0d act=%0d ls=%0d fs=%0d fc=%0d want x=%0d y=%0d tx=%0d ty=%0d sx=%0d sy=%0d act=%0d ls=%0d fs=%0d fc=%0d",
               name, got.x, got.y, got.tx, got.ty, got.sx, got.sy, got.act, got.ls, got.fs, got.fc,
               want.x, want.y, want.tx, want.ty, want.sx, want.sy, want.act, want.ls, want.fs, want.fc);
    end
  endtask

  task automatic check_output();
    check_one("model_a", act_a(), last_exp[0]);
    check_one("model_b", act_b(), last_exp[1]);
  endtask

  // Drive one sample, clock it, update the model and compare both instances.
  task automatic apply_stimulus(input int h, input int v, input bit en);
    hc = 10'(h);
    vc = 10'(v);
    pe = en;
    @(posedge clk);
    #1;
    if (!rst_n)
      model_reset();
    else if (en)
      model_advance(h, v);
    check_output();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply_stimulus(0, 0, 1'b0);
    rst_n = 1'b1;
  endtask

  vec_t vecs [10];
  int   fa[$];
  int   fb[$];
  int   h, v;
  int   n;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    pe    = 1'b0;
    hc    = '0;
    vc    = '0;
    model_reset();

    //          h    v    ax  ay  act ls fs   bx  by  btx bty bsx bsy
    vecs[0] = '{145, 13,   0,  0,  1, 1, 1,    0,  0,  0,  0,  0,  0};
    vecs[1] = '{624, 492, 479, 479, 1, 0, 0,  479, 479, 119, 119, 3, 3};
    vecs[2] = '{625, 492,  0, 479, 0, 0, 0,   479, 479, 119, 119, 3, 3};
    vecs[3] = '{150, 20,   5,  7,  1, 0, 0,    5,  7,  1,  1,  1,  3};
    vecs[4] = '{100, 5,    0,  0,  0, 0, 0,    0,  0,  0,  0,  0,  0};
    vecs[5] = '{145, 300,  0, 287, 1, 1, 0,    0, 287, 0, 71,  0,  3};
    vecs[6] = '{1000, 1000, 0, 0,  0, 0, 0,   479, 479, 119, 119, 3, 3};
    vecs[7] = '{144, 13,   0,  0,  0, 0, 0,    0,  0,  0,  0,  0,  0};
    vecs[8] = '{146, 492,  1, 479, 1, 0, 0,    1, 479, 0, 119,  1,  3};
    vecs[9] = '{624, 12,  479, 0,  0, 0, 0,   479, 0, 119,  0,  3,  0};

    // reset state
    do_reset();
    check_val("reset_a_x", int'(ifa.xcoor), 0);
    check_val("reset_b_active", int'(ifb.active), 0);

    // directed table: hold each sample long enough to reach both outputs
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 3; k++)
        apply_stimulus(vecs[i].h, vecs[i].v, 1'b1);
      check_val($sformatf("tab%0d_a_x", i), int'(ifa.xcoor), vecs[i].ax);
      check_val($sformatf("tab%0d_a_y", i), int'(ifa.ycoor), vecs[i].ay);
      check_val($sformatf("tab%0d_a_act", i), int'(ifa.active), vecs[i].aact);
      check_val($sformatf("tab%0d_a_ls", i), int'(ifa.line_start), vecs[i].als);
      check_val($sformatf("tab%0d_a_fs", i), int'(ifa.frame_start), vecs[i].afs);
      check_val($sformatf("tab%0d_b_x", i), int'(ifb.xcoor), vecs[i].bx);
      check_val($sformatf("tab%0d_b_y", i), int'(ifb.ycoor), vecs[i].by);
      check_val($sformatf("tab%0d_b_tx", i), int'(ifb.tile_x), vecs[i].btx);
      check_val($sformatf("tab%0d_b_ty", i), int'(ifb.tile_y), vecs[i].bty);
      check_val($sformatf("tab%0d_b_sx", i), int'(ifb.sub_x), vecs[i].bsx);
      check_val($sformatf("tab%0d_b_sy", i), int'(ifb.sub_y), vecs[i].bsy);
    end

    // stall with frame_start at the output: held, counted once
    do_reset();
    apply_stimulus(145, 13, 1'b1);
    apply_stimulus(146, 13, 1'b1);
    check_val("stall_fs_arrive", int'(ifa.frame_start), 1);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(146, 13, 1'b0);
      check_val("stall_fs_held", int'(ifa.frame_start), 1);
      check_val("stall_fc_held", int'(ifa.frame_cnt), 0);
    end
    apply_stimulus(147, 13, 1'b1);
    check_val("stall_fs_once", int'(ifa.frame_start), 0);
    check_val("stall_x_next", int'(ifa.xcoor), 1);

    // five short frames: frame_cnt sequence at each frame_start
    do_reset();
    fa.delete();
    fb.delete();
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 4; k++) begin
        case (k)
          0: apply_stimulus(145, 13, 1'b1);
          1: apply_stimulus(146, 13, 1'b1);
          2: apply_stimulus(145, 14, 1'b1);
          default: apply_stimulus(400, 300, 1'b1);
        endcase
        if (ifa.frame_start) fa.push_back(int'(ifa.frame_cnt));
        if (ifb.frame_start) fb.push_back(int'(ifb.frame_cnt));
      end
    end
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(400, 300, 1'b1);
      if (ifa.frame_start) fa.push_back(int'(ifa.frame_cnt));
      if (ifb.frame_start) fb.push_back(int'(ifb.frame_cnt));
    end
    check_val("frames_a_count", fa.size(), 5);
    check_val("frames_b_count", fb.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < fa.size()) check_val($sformatf("frame_a_fc%0d", i), fa[i], i);
      if (i < fb.size()) check_val($sformatf("frame_b_fc%0d", i), fb[i], i % 4);
    end

    // reset mid-line: flush, exact re-fill latency, counter restart
    do_reset();
    apply_stimulus(145, 13, 1'b1);
    apply_stimulus(146, 13, 1'b1);
    apply_stimulus(147, 13, 1'b1);
    apply_stimulus(148, 13, 1'b1);
    apply_stimulus(200, 13, 1'b1);
    rst_n = 1'b0;
    apply_stimulus(300, 13, 1'b1);
    rst_n = 1'b1;
    check_val("midrst_a_x", int'(ifa.xcoor), 0);
    check_val("midrst_a_act", int'(ifa.active), 0);
    check_val("midrst_b_x", int'(ifb.xcoor), 0);
    check_val("midrst_b_act", int'(ifb.active), 0);
    apply_stimulus(150, 20, 1'b1);
    check_val("refill1_b_x", int'(ifb.xcoor), 0);
    apply_stimulus(150, 20, 1'b0);
    check_val("refill_stall_b_x", int'(ifb.xcoor), 0);
    apply_stimulus(151, 20, 1'b1);
    check_val("refill2_b_x", int'(ifb.xcoor), 0);
    apply_stimulus(152, 20, 1'b1);
    check_val("refill3_b_x", int'(ifb.xcoor), 5);
    check_val("refill3_b_act", int'(ifb.active), 1);
    apply_stimulus(145, 13, 1'b1);
    apply_stimulus(146, 13, 1'b1);
    apply_stimulus(147, 13, 1'b1);
    check_val("restart_b_fs", int'(ifb.frame_start), 1);
    check_val("restart_b_fc", int'(ifb.frame_cnt), 0);

    // randomized samples against the model, with stalls and rare resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      n = int'($urandom_range(0, 7));
      h = (n == 0) ? 145 : (n == 1) ? 624 : (n == 2) ? 625 : int'($urandom_range(100, 700));
      n = int'($urandom_range(0, 7));
      v = (n == 0) ? 13 : (n == 1) ? 492 : (n == 2) ? 493 : int'($urandom_range(0, 540));
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        apply_stimulus(h, v, 1'($urandom_range(0, 1)));
        rst_n = 1'b1;
      end else begin
        apply_stimulus(h, v, ($urandom_range(0, 3) != 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
